// File: rtl/core_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter_if
// Bundles the signals around the core bus arbiter:
//   ibus : i_valid, i_addr           -> arbiter ; i_data_ok, i_rdata -> core
//   dbus : d_valid, d_addr, d_size,
//          d_strobe, d_wdata          -> arbiter ; d_data_ok, d_rdata -> core
//   mem  : m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata -> memory
//          m_ready, m_rdata           -> arbiter
// Modport 'slave' is the arbiter's view. Modport 'master' is the view of the
// surrounding core and memory model, which drive the requests and responses.
// -----------------------------------------------------------------------------
interface core_bus_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_rdata;

  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_data_ok;
  logic [63:0] d_rdata;

  logic        m_valid;
  logic        m_is_write;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic [63:0] m_rdata;

  modport slave (
    input  i_valid, i_addr,
    output i_data_ok, i_rdata,
    input  d_valid, d_addr, d_size, d_strobe, d_wdata,
    output d_data_ok, d_rdata,
    output m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
    input  m_ready, m_rdata
  );

  modport master (
    output i_valid, i_addr,
    input  i_data_ok, i_rdata,
    output d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  d_data_ok, d_rdata,
    input  m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter
// Shares one downstream single-beat memory bus between the instruction-fetch
// port (ibus) and the data port (dbus). Ties are broken round-robin; every
// transaction runs IDLE -> BUSY -> DONE so at most one issues every 3 cycles.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : core_bus_arbiter_if.slave (ibus, dbus and memory-side signals)
// Parameter:
//   DATA_FIRST : 1 = dbus wins the first tie after reset, 0 = ibus does.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module core_bus_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  core_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWN_IBUS = 1'b0;
  localparam logic OWN_DBUS = 1'b1;
  // 'last' starts on the port that should lose the first tie.
  localparam logic LAST_RST = DATA_FIRST ? OWN_IBUS : OWN_DBUS;

  // Picks the 32-bit instruction out of the 64-bit beat.
  function automatic logic [31:0] ibus_word(input logic [63:0] beat, input logic hi);
    logic [31:0] word;
    if (hi) begin
      word = beat[63:32];
    end else begin
      word = beat[31:0];
    end
    return word;
  endfunction

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        m_valid_q, m_valid_d;
  logic        m_is_write_q, m_is_write_d;
  logic [63:0] m_addr_q, m_addr_d;
  logic [2:0]  m_size_q, m_size_d;
  logic [7:0]  m_strobe_q, m_strobe_d;
  logic [63:0] m_wdata_q, m_wdata_d;
  logic        i_data_ok_q, i_data_ok_d;
  logic        d_data_ok_q, d_data_ok_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        grant_dbus_s;

  // Next-state, grant selection and output register inputs.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    m_valid_d    = 1'b0;
    m_is_write_d = m_is_write_q;
    m_addr_d     = m_addr_q;
    m_size_d     = m_size_q;
    m_strobe_d   = m_strobe_q;
    m_wdata_d    = m_wdata_q;
    i_data_ok_d  = 1'b0;
    d_data_ok_d  = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    // dbus wins when it is alone, or on a tie when ibus was served last.
    grant_dbus_s = bus.d_valid & (~bus.i_valid | (last_q == OWN_IBUS));

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid | bus.d_valid) begin
          state_d   = ST_BUSY;
          m_valid_d = 1'b1;
          owner_d   = grant_dbus_s;
          last_d    = grant_dbus_s;
          if (grant_dbus_s) begin
            m_addr_d     = bus.d_addr;
            m_size_d     = bus.d_size;
            m_strobe_d   = bus.d_strobe;
            m_wdata_d    = bus.d_wdata;
            m_is_write_d = |bus.d_strobe;
          end else begin
            m_addr_d     = bus.i_addr;
            m_size_d     = 3'd2;
            m_strobe_d   = 8'h00;
            m_wdata_d    = 64'd0;
            m_is_write_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Request fields are frozen here; core-side inputs are not looked at.
        if (bus.m_ready) begin
          state_d = ST_DONE;
          if (owner_q == OWN_DBUS) begin
            d_data_ok_d = 1'b1;
            d_rdata_d   = bus.m_rdata;
          end else begin
            i_data_ok_d = 1'b1;
            i_rdata_d   = ibus_word(bus.m_rdata, m_addr_q[2]);
          end
        end else begin
          m_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        // No arbitration here: the owner's valid is still high this cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_q       <= LAST_RST;
      owner_q      <= OWN_IBUS;
      m_valid_q    <= 1'b0;
      m_is_write_q <= 1'b0;
      m_addr_q     <= 64'd0;
      m_size_q     <= 3'd0;
      m_strobe_q   <= 8'h00;
      m_wdata_q    <= 64'd0;
      i_data_ok_q  <= 1'b0;
      d_data_ok_q  <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      m_valid_q    <= m_valid_d;
      m_is_write_q <= m_is_write_d;
      m_addr_q     <= m_addr_d;
      m_size_q     <= m_size_d;
      m_strobe_q   <= m_strobe_d;
      m_wdata_q    <= m_wdata_d;
      i_data_ok_q  <= i_data_ok_d;
      d_data_ok_q  <= d_data_ok_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.m_valid    = m_valid_q;
  assign bus.m_is_write = m_is_write_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_size     = m_size_q;
  assign bus.m_strobe   = m_strobe_q;
  assign bus.m_wdata    = m_wdata_q;
  assign bus.i_data_ok  = i_data_ok_q;
  assign bus.i_rdata    = i_rdata_q;
  assign bus.d_data_ok  = d_data_ok_q;
  assign bus.d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_bus_arbiter
// Directed scenarios followed by random core/memory traffic. A transaction
// level reference model predicts every cycle's outputs from the inputs.
// -----------------------------------------------------------------------------
module tb_core_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  core_bus_arbiter_if bus();

  core_bus_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } req_t;

  req_t        mdl_req;
  bit          mdl_open;        // a granted transaction is outstanding
  bit          mdl_is_dbus;
  bit          mdl_last_dbus;   // port served most recently
  int          mdl_cycle;
  int          mdl_idle_from;   // earliest cycle whose end may carry a grant
  bit          exp_m_valid, exp_i_ok, exp_d_ok;
  logic [31:0] exp_i_rdata;
  logic [63:0] exp_d_rdata;

  task automatic model_reset();
    mdl_req       = '0;
    mdl_open      = 1'b0;
    mdl_is_dbus   = 1'b0;
    mdl_last_dbus = 1'b0;       // DATA_FIRST=1: ibus counts as served last
    mdl_idle_from = mdl_cycle;
    exp_m_valid   = 1'b0;
    exp_i_ok      = 1'b0;
    exp_d_ok      = 1'b0;
    exp_i_rdata   = 32'd0;
    exp_d_rdata   = 64'd0;
  endtask

  // Predicts outputs after the coming rising edge from the inputs now driven.
  task automatic model_update();
    bit pick_d;
    exp_i_ok = 1'b0;
    exp_d_ok = 1'b0;
    if (mdl_open) begin
      if (bus.m_ready) begin
        if (mdl_is_dbus) begin
          exp_d_ok    = 1'b1;
          exp_d_rdata = bus.m_rdata;
        end else begin
          exp_i_ok    = 1'b1;
          exp_i_rdata = mdl_req.addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
        end
        mdl_open      = 1'b0;
        // one cycle of completion pulse, one idle cycle, then a grant
        mdl_idle_from = mdl_cycle + 2;
      end
    end else if (mdl_cycle >= mdl_idle_from && (bus.i_valid || bus.d_valid)) begin
      if (bus.i_valid && bus.d_valid) pick_d = !mdl_last_dbus;
      else                            pick_d = bus.d_valid;
      if (pick_d) begin
        mdl_req.addr     = bus.d_addr;
        mdl_req.size     = bus.d_size;
        mdl_req.strobe   = bus.d_strobe;
        mdl_req.wdata    = bus.d_wdata;
        mdl_req.is_write = (bus.d_strobe != 8'h00);
      end else begin
        mdl_req.addr     = bus.i_addr;
        mdl_req.size     = 3'd2;
        mdl_req.strobe   = 8'h00;
        mdl_req.wdata    = 64'd0;
        mdl_req.is_write = 1'b0;
      end
      mdl_is_dbus   = pick_d;
      mdl_last_dbus = pick_d;
      mdl_open      = 1'b1;
    end
    exp_m_valid = mdl_open;
    mdl_cycle++;
  endtask

  // One clock: model the coming edge, then compare at the falling edge.
  task automatic step();
    model_update();
    @(negedge clk);
    check_eq("m_valid",   64'(bus.m_valid),   64'(exp_m_valid));
    check_eq("i_data_ok", 64'(bus.i_data_ok), 64'(exp_i_ok));
    check_eq("d_data_ok", 64'(bus.d_data_ok), 64'(exp_d_ok));
    check_eq("i_rdata",   64'(bus.i_rdata),   64'(exp_i_rdata));
    check_eq("d_rdata",   bus.d_rdata,        exp_d_rdata);
    if (exp_m_valid) begin
      check_eq("m_addr",     bus.m_addr,            mdl_req.addr);
      check_eq("m_size",     64'(bus.m_size),       64'(mdl_req.size));
      check_eq("m_strobe",   64'(bus.m_strobe),     64'(mdl_req.strobe));
      check_eq("m_wdata",    bus.m_wdata,           mdl_req.wdata);
      check_eq("m_is_write", 64'(bus.m_is_write),   64'(mdl_req.is_write));
    end
  endtask

  task automatic clear_inputs();
    bus.i_valid  = 1'b0;
    bus.i_addr   = 64'd0;
    bus.d_valid  = 1'b0;
    bus.d_addr   = 64'd0;
    bus.d_size   = 3'd0;
    bus.d_strobe = 8'h00;
    bus.d_wdata  = 64'd0;
    bus.m_ready  = 1'b0;
    bus.m_rdata  = 64'd0;
  endtask

  logic [63:0] grant_addr_q[$];
  logic [63:0] held_addr;
  logic [63:0] held_wdata;

  initial begin
    clear_inputs();
    mdl_cycle = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_m_valid",   64'(bus.m_valid),   64'd0);
    check_eq("rst_m_addr",    bus.m_addr,         64'd0);
    check_eq("rst_m_size",    64'(bus.m_size),    64'd0);
    check_eq("rst_i_data_ok", 64'(bus.i_data_ok), 64'd0);
    check_eq("rst_d_data_ok", 64'(bus.d_data_ok), 64'd0);
    check_eq("rst_d_rdata",   bus.d_rdata,        64'd0);
    reset = 1'b1;
    step();

    // ibus alone
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h0000_0000_8000_0004;
    step();
    check_eq("ib_m_valid",  64'(bus.m_valid),  64'd1);
    check_eq("ib_m_size",   64'(bus.m_size),   64'd2);
    check_eq("ib_m_strobe", 64'(bus.m_strobe), 64'd0);
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'hDEADBEEF_00000013;
    step();
    check_eq("ib_i_data_ok", 64'(bus.i_data_ok), 64'd1);
    check_eq("ib_i_rdata",   64'(bus.i_rdata),   64'hDEADBEEF);
    check_eq("ib_d_data_ok", 64'(bus.d_data_ok), 64'd0);
    bus.i_valid = 1'b0;
    bus.m_ready = 1'b0;
    step();
    check_eq("ib_pulse_len", 64'(bus.i_data_ok), 64'd0);

    // Downstream wait: dbus store held off for 5 BUSY cycles
    bus.d_valid  = 1'b1;
    bus.d_addr   = 64'h0000_0000_8000_3008;
    bus.d_size   = 3'd3;
    bus.d_strobe = 8'h0F;
    bus.d_wdata  = 64'hCAFE_F00D_1234_5678;
    step();
    held_addr  = bus.m_addr;
    held_wdata = bus.m_wdata;
    bus.d_addr = 64'h0000_0000_1111_1111;   // ignored while BUSY
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("wait_m_valid", 64'(bus.m_valid), 64'd1);
      check_eq("wait_m_addr",  bus.m_addr,        held_addr);
      check_eq("wait_m_wdata", bus.m_wdata,       held_wdata);
      check_eq("wait_no_ok",   64'(bus.d_data_ok), 64'd0);
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h0BAD_C0DE_0000_0001;
    step();
    check_eq("wait_d_data_ok", 64'(bus.d_data_ok), 64'd1);

    // Held valid through DONE: no re-grant until after the idle cycle
    bus.m_ready = 1'b0;
    step();
    check_eq("held_no_regrant", 64'(bus.m_valid), 64'd0);
    step();
    check_eq("held_next_grant", 64'(bus.m_valid), 64'd1);

    // Reset mid-transaction (dbus in BUSY, dbus served last)
    #2 reset = 1'b0;
    #1;
    check_eq("mr_m_valid",   64'(bus.m_valid),   64'd0);
    check_eq("mr_m_addr",    bus.m_addr,         64'd0);
    check_eq("mr_d_data_ok", 64'(bus.d_data_ok), 64'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step();
    check_eq("mr_no_pulse", 64'(bus.d_data_ok), 64'd0);

    // Simultaneous requests after reset: dbus first, then strict alternation
    bus.i_valid  = 1'b1;
    bus.i_addr   = 64'h0000_0000_8000_0100;
    bus.d_valid  = 1'b1;
    bus.d_addr   = 64'h0000_0000_8000_1000;
    bus.d_size   = 3'd3;
    bus.d_strobe = 8'hFF;
    bus.d_wdata  = 64'h0000_0000_0000_1234;
    step();
    check_eq("sim_first_addr",  bus.m_addr,          64'h0000_0000_8000_1000);
    check_eq("sim_is_write",    64'(bus.m_is_write), 64'd1);
    check_eq("sim_wdata",       bus.m_wdata,         64'h0000_0000_0000_1234);
    grant_addr_q.push_back(bus.m_addr);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.m_rdata = {$urandom, $urandom};
      step();
      if (bus.m_valid) grant_addr_q.push_back(bus.m_addr);
    end
    check_eq("alt_count", 64'(grant_addr_q.size()), 64'd4);
    for (int k = 0; k < grant_addr_q.size(); k++) begin
      check_eq("alt_order", grant_addr_q[k],
               (k % 2 == 0) ? 64'h0000_0000_8000_1000 : 64'h0000_0000_8000_0100);
    end
    bus.i_valid = 1'b0;
    bus.d_valid = 1'b0;
    repeat (3) step();
    bus.m_ready = 1'b0;
    step();

    // Sub-word load: full beat is returned to the core
    bus.d_valid  = 1'b1;
    bus.d_addr   = 64'h0000_0000_8000_2003;
    bus.d_size   = 3'd0;
    bus.d_strobe = 8'h00;
    bus.d_wdata  = 64'd0;
    step();
    check_eq("sub_is_write", 64'(bus.m_is_write), 64'd0);
    check_eq("sub_size",     64'(bus.m_size),     64'd0);
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    check_eq("sub_d_rdata", bus.d_rdata, 64'h0123_4567_89AB_CDEF);
    bus.d_valid = 1'b0;
    bus.m_ready = 1'b0;
    step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (bus.i_data_ok || !bus.i_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.i_valid = 1'b1;
          bus.i_addr  = {$urandom, $urandom};
        end else begin
          bus.i_valid = 1'b0;
        end
      end else if ($urandom_range(0, 63) == 0) begin
        bus.i_valid = 1'b0;
      end
      if (bus.d_data_ok || !bus.d_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.d_valid  = 1'b1;
          bus.d_addr   = {$urandom, $urandom};
          bus.d_size   = 3'($urandom_range(0, 3));
          bus.d_strobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          bus.d_wdata  = {$urandom, $urandom};
        end else begin
          bus.d_valid = 1'b0;
        end
      end else if ($urandom_range(0, 63) == 0) begin
        bus.d_valid = 1'b0;
      end
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.m_rdata = {$urandom, $urandom};
      step();
    end

    clear_inputs();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Two-port arbiter that shares the single downstream memory bus between the core's instruction-fetch port (ibus) and data port (dbus). It sits between the core's `ireq`/`iresp` and `dreq`/`dresp` handshakes and the memory/cache interface. Each core-side port keeps its existing valid/data_ok protocol. The arbiter serialises single-beat transactions with round-robin fairness and a registered, glitch-free downstream request.

## Interface
- `DATA_FIRST`, default 1: which port wins the first tie after reset; 1 = dbus, 0 = ibus.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 forces the reset state immediately.
- `i_valid`  in  1  ibus request valid; held until `i_data_ok`.
- `i_addr`  in  64  ibus address.
- `i_data_ok`  out  1  one-cycle ibus completion pulse.
- `i_rdata`  out  32  fetched instruction; valid while `i_data_ok`=1.
- `d_valid`  in  1  dbus request valid; held until `d_data_ok`.
- `d_addr`  in  64  dbus address.
- `d_size`  in  3  log2 access bytes, 0–3.
- `d_strobe`  in  8  byte write enables; 0 = read.
- `d_wdata`  in  64  store data.
- `d_data_ok`  out  1  one-cycle dbus completion pulse.
- `d_rdata`  out  64  load data; valid while `d_data_ok`=1.
- `m_valid`  out  1  downstream request valid.
- `m_is_write`  out  1  1 when the latched `d_strobe`≠0.
- `m_addr`  out  64  latched address.
- `m_size`  out  3  latched size; ibus grant uses 2 (4 bytes).
- `m_strobe`  out  8  latched strobe; 0 for ibus.
- `m_wdata`  out  64  latched store data; 0 for ibus.
- `m_ready`  in  1  downstream accepts and completes the single beat this cycle.
- `m_rdata`  in  64  read data; valid when `m_ready`=1.

## Operation
- FSM has three states: IDLE, BUSY and DONE. The reset state is IDLE.
- **IDLE**
  - If neither valid is set, stay in IDLE.
  - If exactly one valid is set, grant that port.
  - If both are set, grant the port not served last. The `last` register resets to ibus when `DATA_FIRST`=1 and to dbus when `DATA_FIRST`=0.
  - On a grant, latch the selected port's request fields into the `m_*` registers, record the owner, set `last` to the owner, and go to BUSY.
- **BUSY**
  - `m_valid`=1 and the `m_*` fields stay constant. Core-side input changes are ignored.
  - On `m_ready`=1:
    - Capture `m_rdata`.
    - For an ibus owner, select the 32-bit word using `m_addr[2]`: 1 selects `[63:32]`, 0 selects `[31:0]`.
    - Go to DONE.
  - There is no timeout; the arbiter waits indefinitely.
- **DONE**
  - The owner's `*_data_ok`=1 for exactly this cycle, with the captured data. The other port's `*_data_ok` stays 0.
  - No arbitration happens in DONE. This prevents re-granting the owner, whose valid is still high during this cycle.
  - Go to IDLE next cycle.
- If the owner drops its valid during BUSY (a protocol violation), the transaction still completes and `*_data_ok` still pulses.
- A port that is not granted keeps its request pending. Its `*_data_ok` stays 0, which the core sees as a wait.
- `*_rdata` outputs hold their last captured value outside DONE. Only `*_data_ok` qualifies them.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values: `m_valid`=0; all `m_*` fields=0; `i_data_ok`=`d_data_ok`=0; `i_rdata`=0; `d_rdata`=0; state IDLE; `last` set per `DATA_FIRST`.
- Assume valid rises in cycle 0 with the FSM in IDLE:
  - The grant is made at the end of cycle 0, and `m_valid`=1 from cycle 1.
  - If `m_ready`=1 in cycle 1, `*_data_ok`=1 in cycle 2. This is the minimum latency of 2 cycles.
  - The FSM is back in IDLE in cycle 3, and the next `m_valid` is cycle 4 at the earliest.
- One transaction issues per 3 cycles at best. With both ports continuously valid, grants strictly alternate.
- If `m_ready` is held high while `m_valid`=0, it has no effect.
- A reset assertion in any state clears all outputs in the same cycle. An in-flight transaction is abandoned and `*_data_ok` does not pulse.

## Test plan
- **ibus alone:** Drive `i_valid`=1, `i_addr`=0x8000_0004, then `m_ready`=1 one cycle after `m_valid` with `m_rdata`=0xDEADBEEF_00000013. Expect `m_size`=2, `m_strobe`=0, and `i_data_ok` for 1 cycle with `i_rdata`=0xDEADBEEF. `d_data_ok` stays 0.
- **Simultaneous requests after reset, `DATA_FIRST`=1:** Drive `i_valid` and `d_valid` in the same cycle, with a dbus store: `d_addr`=0x8000_1000, `d_strobe`=0xFF, `d_wdata`=0x1234. Expect the first grant to dbus with `m_is_write`=1 and `m_wdata`=0x1234. Expect the second grant to ibus. Grants then alternate: I, D, I while both stay valid.
- **Downstream wait:** Hold `m_ready`=0 for 5 BUSY cycles. Expect `m_valid` and every `m_*` field constant across all 5 cycles, with no `data_ok`. On `m_ready`=1, expect `data_ok` exactly 1 cycle later.
- **Held valid through DONE:** Keep `d_valid`=1 during and one cycle after `d_data_ok`. Expect no duplicate grant in the DONE cycle. The next grant comes from IDLE, 2 cycles after DONE at the earliest.
- **Reset mid-transaction:** Pull `reset` to 0 asynchronously while in BUSY. Expect `m_valid`=0 within the same cycle. After release, expect no `data_ok` pulse and `last` restored to its reset value.
- **Sub-word load:** Drive `d_size`=0, `d_strobe`=0, `d_addr`=0x8000_2003. Expect `m_is_write`=0, `m_size`=0, and `d_rdata` equal to the full 64-bit `m_rdata`. The core does the byte extraction.
